imem: RTL and testbench
=======================

// Module: imem
// PURPOSE
//   Single-port 32-bit instruction memory for the RISC-V core's fetch path.
//   It is built from registers, so asynchronous reset can clear every word.
//   Word-addressed. Synchronous read and write, with a registered read port.
//   The fetch stage reads it (rw=1). Loader/debug logic writes it (rw=0).
// PARAMETERS
//   DEPTH  256  number of 32-bit words (power of two, >=2)
//   AW     $clog2(DEPTH)  index width, derived; do not override
// PORTS
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-low reset (0 = reset asserted)
//   address   in   32  word index; bits [AW-1:0] used
//   rw        in   1   1 = read, 0 = write
//   data_in   in   32  write data, sampled when rw=0
//   data_out  out  32  registered read data
// BEHAVIOUR
// - Reset (reset=0, async): data_out=32'h0 and every mem word = RST_WORD.
//   Reset dominates clk. No access completes while reset=0.
// - Read (rw=1), at posedge clk: data_out <= mem[address]. Latency 1 cycle.
// - Write (rw=0), at posedge clk: mem[address] <= data_in.
//   data_out holds its previous value (no write-through).
// - Out of range (address >= DEPTH, any bit above AW-1 set):
//   read loads data_out=32'h0, write is dropped. Index never wraps.
// - Read after write to the same word: the next read cycle returns the new data.
// - Reset released mid-sequence: the first posedge after reset=1 is a normal access.
// - data_in is ignored when rw=1. address/rw/data_in need only be stable at posedge.
// CONFIGURATION
//   IMEM_NOP_FILL_EN defined: RST_WORD = 32'h0000_0013 (addi x0,x0,0 NOP),
//     so a fetch from cleared memory executes NOPs.
//   IMEM_NOP_FILL_EN undefined: RST_WORD = 32'h0000_0000.
//   Out-of-range reads return 0 in both cases.
// STRUCTURE
//   Package imem_pkg: XLEN=32, NOP_INSTR=32'h0000_0013,
//     typedef word_t = logic [XLEN-1:0].
//   Single module. Storage is a reg array, range check is combinational.
//   No sub-module.
// TESTING
// 1. Reset 0->1, then read addr 1 -> data_out=0
//    (0x00000013 with IMEM_NOP_FILL_EN).
// 2. Write addr 1 with 0x00168693 (rw=0), then rw=1 addr 1 ->
//    data_out=0x00168693 one edge later.
//    data_out unchanged during the write cycle.
// 3. After test 2, pulse reset=0 for 100ns, then read addr 1 ->
//    data_out=0 (or NOP); mem is cleared.
// 4. Write addr 1 with 0x00000713, then read addr 1 -> 0x00000713.
//    Read addr 0 and addr 2 -> reset value (no aliasing).
// 5. Write addr DEPTH with 0xDEADBEEF, then read addr 0 -> reset value.
//    Read addr DEPTH -> 0.
// 6. Assert reset=0 between clock edges while rw=1 ->
//    data_out goes 0 immediately, not at the next posedge.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory.
// Defining IMEM_NOP_FILL_EN makes reset fill memory with NOPs instead of zero.
package imem_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0013;

`ifdef IMEM_NOP_FILL_EN
  localparam word_t RST_WORD = NOP_INSTR;
`else
  localparam word_t RST_WORD = '0;
`endif

  typedef enum logic {
    ACC_WRITE = 1'b0,
    ACC_READ  = 1'b1
  } access_e;

endpackage

// File: rtl/imem.sv
// Register-based single-port instruction memory with registered read data.
// Reset contents come from imem_pkg::RST_WORD (see IMEM_NOP_FILL_EN).
module imem
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        rw,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  word_t           mem [DEPTH];
  logic [AW-1:0]   idx;
  logic            in_range;
  access_e         access;

  // Any address bit above the index field marks the access out of range; no wrap.
  always_comb begin
    idx      = address[AW-1:0];
    in_range = (address[31:AW] == '0);
    access   = access_e'(rw);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_WORD;
      end
    end else if (access == ACC_WRITE && in_range) begin
      mem[idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (access == ACC_READ) begin
      data_out <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_imem.sv
// Directed, table-driven check of imem: reset contents, read/write, range handling.
module tb_imem;
  import imem_pkg::*;

  localparam int unsigned DEPTH = 16;
`ifdef IMEM_NOP_FILL_EN
  localparam logic [31:0] RST = 32'h0000_0013;
`else
  localparam logic [31:0] RST = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rw = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          pre_reset;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    vecs = '{
      '{1'b0, 1'b1, 32'd1,           32'hDEAD_DEAD, RST},          // din ignored on read
      '{1'b0, 1'b0, 32'd1,           32'h0016_8693, RST},          // write holds data_out
      '{1'b0, 1'b1, 32'd1,           32'h0,         32'h0016_8693},
      '{1'b1, 1'b1, 32'd1,           32'h0,         RST},          // reset cleared mem
      '{1'b0, 1'b1, 32'd5,           32'h0,         RST},          // write during reset dropped
      '{1'b0, 1'b0, 32'd1,           32'h0000_0713, RST},
      '{1'b0, 1'b1, 32'd1,           32'h0,         32'h0000_0713},
      '{1'b0, 1'b1, 32'd0,           32'h0,         RST},
      '{1'b0, 1'b1, 32'd2,           32'h0,         RST},
      '{1'b0, 1'b0, DEPTH,           32'hDEAD_BEEF, RST},
      '{1'b0, 1'b1, 32'd0,           32'h0,         RST},          // no wrap to 0
      '{1'b0, 1'b1, DEPTH,           32'h0,         32'h0},        // OOR read -> 0
      '{1'b0, 1'b0, 32'd3,           32'h0000_00A5, 32'h0},
      '{1'b0, 1'b1, 32'd3,           32'h0,         32'h0000_00A5},
      '{1'b0, 1'b0, DEPTH + 3,       32'h0000_0011, 32'h0000_00A5},
      '{1'b0, 1'b1, 32'd3,           32'h0,         32'h0000_00A5},
      '{1'b0, 1'b1, DEPTH - 1,       32'h0,         RST},
      '{1'b0, 1'b0, DEPTH - 1,       32'h0000_1234, RST},
      '{1'b0, 1'b1, DEPTH - 1,       32'h0,         32'h0000_1234},
      '{1'b0, 1'b0, 32'h8000_0001,   32'h0000_00FF, 32'h0000_1234},
      '{1'b0, 1'b1, 32'h8000_0001,   32'h0,         32'h0},
      '{1'b0, 1'b1, 32'd1,           32'h0,         32'h0000_0713}
    };

    #1 check("reset_state", data_out, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (vecs[i].pre_reset) begin
        rw = 1'b0;
        address = 32'd5;
        data_in = 32'hBAD0_0005;
        reset = 1'b0;
        #1 check("reset_pulse_clear", data_out, 32'h0);
        #99 reset = 1'b1;
      end
      rw = vecs[i].rw;
      address = vecs[i].addr;
      data_in = vecs[i].din;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), data_out, vecs[i].exp);
    end

    // Mid-cycle async reset while reading, then first edge after release is a normal read
    @(negedge clk);
    rw = 1'b1;
    address = 32'd3;
    data_in = '0;
    @(posedge clk);
    #1 check("pre_async_read", data_out, 32'h0000_00A5);
    #2 reset = 1'b0;
    #1 check("async_reset_immediate", data_out, 32'h0);
    @(posedge clk);
    #1 check("no_access_in_reset", data_out, 32'h0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1 check("first_edge_after_release", data_out, RST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
